// File: rtl/robo_ctrl_if.sv
// Command/sensor bundle between the maze-solving controller and the maze simulator.
// The master side (simulator or bench) drives run and the sensors; the slave (controller) drives commands.
interface robo_ctrl_if;
  logic       run;
  logic       head_in;
  logic       left_in;
  logic       under_in;
  logic       barrier_in;
  logic       avancar;
  logic       girar;
  logic       remover;
  logic       done;
  logic [7:0] steps;

  modport master (
    output run, head_in, left_in, under_in, barrier_in,
    input  avancar, girar, remover, done, steps
  );

  modport slave (
    input  run, head_in, left_in, under_in, barrier_in,
    output avancar, girar, remover, done, steps
  );
endinterface

// File: rtl/robo_ctrl.sv
// Left-hand-rule maze controller: senses, then issues one forward/turn/remove command,
// with barrier removal that gives up after REMOVE_MAX cycles and treats the barrier as a wall.
module robo_ctrl #(
  parameter int unsigned REMOVE_MAX  = 15,
  parameter int unsigned RIGHT_TURNS = 3
) (
  input  logic        selected_clock,
  input  logic        reset,
  robo_ctrl_if.slave  bus
);

  localparam int unsigned         REM_W     = (REMOVE_MAX > 1) ? $clog2(REMOVE_MAX) : 1;
  localparam logic [REM_W-1:0]    REM_LAST  = REM_W'(REMOVE_MAX - 1);
  localparam logic [REM_W-1:0]    REM_ONE   = REM_W'(1);
  localparam logic [1:0]          TURN_LAST = 2'(RIGHT_TURNS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SENSE  = 3'd1,
    TURN_L = 3'd2,
    FWD    = 3'd3,
    TURN_R = 3'd4,
    REMOVE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_left_lock;
  logic             w_next_lock;
  logic [1:0]       r_turn_cnt;
  logic [1:0]       w_next_turn;
  logic [REM_W-1:0] r_rem_cnt;
  logic [REM_W-1:0] w_next_rem;
  logic             r_avancar;
  logic             r_girar;
  logic             r_remover;
  logic             r_done;
  logic [7:0]       r_steps;
  logic [7:0]       w_next_steps;

  // Next-state, counter and lock decisions
  always_comb begin
    w_next_state = r_state;
    w_next_lock  = r_left_lock;
    w_next_turn  = r_turn_cnt;
    w_next_rem   = r_rem_cnt;
    case (r_state)
      IDLE: begin
        if (bus.run) begin
          w_next_state = SENSE;
        end else begin
          w_next_state = IDLE;
        end
      end
      SENSE: begin
        if (!bus.run) begin
          w_next_state = IDLE;
        end else if (bus.under_in) begin
          w_next_state = DONE;
        end else if (!bus.left_in && !r_left_lock) begin
          // Lock stops a second left turn until we have moved or turned right.
          w_next_state = TURN_L;
          w_next_lock  = 1'b1;
        end else if (bus.barrier_in) begin
          w_next_state = REMOVE;
          w_next_rem   = '0;
        end else if (!bus.head_in) begin
          w_next_state = FWD;
          w_next_lock  = 1'b0;
        end else begin
          w_next_state = TURN_R;
          w_next_lock  = 1'b0;
          w_next_turn  = 2'd0;
        end
      end
      TURN_L: w_next_state = SENSE;
      FWD:    w_next_state = SENSE;
      TURN_R: begin
        if (r_turn_cnt == TURN_LAST) begin
          w_next_state = SENSE;
          w_next_turn  = 2'd0;
        end else begin
          w_next_turn  = r_turn_cnt + 2'd1;
        end
      end
      REMOVE: begin
        if (!bus.barrier_in) begin
          w_next_state = SENSE;
          w_next_rem   = '0;
        end else if (r_rem_cnt == REM_LAST) begin
          // Barrier would not clear: handle it like a wall.
          w_next_state = TURN_R;
          w_next_lock  = 1'b0;
          w_next_turn  = 2'd0;
          w_next_rem   = '0;
        end else begin
          w_next_rem   = r_rem_cnt + REM_ONE;
        end
      end
      DONE:    w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Step counter update, saturating at 255
  always_comb begin
    if ((w_next_state == FWD) && (r_steps != 8'hFF)) begin
      w_next_steps = r_steps + 8'd1;
    end else begin
      w_next_steps = r_steps;
    end
  end

  // State, counters and registered command outputs
  always_ff @(posedge selected_clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_left_lock <= 1'b0;
      r_turn_cnt  <= 2'd0;
      r_rem_cnt   <= '0;
      r_steps     <= 8'd0;
      r_avancar   <= 1'b0;
      r_girar     <= 1'b0;
      r_remover   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_left_lock <= w_next_lock;
      r_turn_cnt  <= w_next_turn;
      r_rem_cnt   <= w_next_rem;
      r_steps     <= w_next_steps;
      r_avancar   <= (w_next_state == FWD);
      r_girar     <= (w_next_state == TURN_L) || (w_next_state == TURN_R);
      r_remover   <= (w_next_state == REMOVE);
      r_done      <= (w_next_state == DONE);
    end
  end

  assign bus.avancar = r_avancar;
  assign bus.girar   = r_girar;
  assign bus.remover = r_remover;
  assign bus.done    = r_done;
  assign bus.steps   = r_steps;

endmodule

// File: tb/tb_robo_ctrl.sv
// Directed bench for robo_ctrl: expected per-cycle {done,avancar,girar,remover} words are
// queued as stimulus is applied and compared one per clock edge.
module tb_robo_ctrl;

  logic selected_clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  localparam logic [3:0] C0 = 4'b0000;
  localparam logic [3:0] CA = 4'b0100;
  localparam logic [3:0] CG = 4'b0010;
  localparam logic [3:0] CR = 4'b0001;
  localparam logic [3:0] CD = 4'b1000;

  logic [3:0] exp_q[$];

  robo_ctrl_if ifc ();

  robo_ctrl dut (
    .selected_clock (selected_clock),
    .reset          (reset),
    .bus            (ifc.slave)
  );

  always #5 selected_clock = ~selected_clock;

  function automatic logic [3:0] obs_cmd();
    return {ifc.done, ifc.avancar, ifc.girar, ifc.remover};
  endfunction

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One edge per queued word; the loop is bounded by the queue length.
  task automatic drain(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      @(posedge selected_clock);
      #1;
      e = exp_q.pop_front();
      chk(tag, {4'h0, obs_cmd()}, {4'h0, e});
    end
  endtask

  initial begin
    reset          = 1'b1;
    ifc.run        = 1'b0;
    ifc.head_in    = 1'b0;
    ifc.left_in    = 1'b0;
    ifc.under_in   = 1'b0;
    ifc.barrier_in = 1'b0;
    #12;
    chk("reset_cmd", {4'h0, obs_cmd()}, 8'h00);
    chk("reset_steps", ifc.steps, 8'd0);
    @(negedge selected_clock);
    reset = 1'b0;
    push(C0, 2);
    drain("idle_no_run");

    // Straight corridor: SENSE/FWD alternation, ten pulses
    ifc.run     = 1'b1;
    ifc.left_in = 1'b1;
    ifc.head_in = 1'b0;
    push(C0, 1);
    for (int i = 0; i < 10; i++) begin
      push(CA, 1);
      push(C0, 1);
    end
    drain("corridor");
    chk("corridor_steps", ifc.steps, 8'd10);

    // Dead end: three girar cycles then SENSE
    ifc.head_in = 1'b1;
    push(CG, 3);
    push(C0, 1);
    drain("dead_end");

    // Open cell: one left turn, then forward, never two lefts in a row
    ifc.left_in = 1'b0;
    ifc.head_in = 1'b0;
    push(CG, 1);
    push(C0, 1);
    push(CA, 1);
    push(C0, 1);
    drain("open_cell");
    chk("open_steps", ifc.steps, 8'd11);

    // BARRIER9: barrier clears once nine remover cycles have been applied
    ifc.left_in    = 1'b1;
    ifc.barrier_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(CR, 1);
      drain("barrier9_rem");
    end
    ifc.barrier_in = 1'b0;
    push(C0, 1);
    push(CA, 1);
    push(C0, 1);
    drain("barrier9_after");
    chk("barrier9_steps", ifc.steps, 8'd12);

    // Stuck barrier: timeout after 15 remover cycles, then a right turn
    ifc.barrier_in = 1'b1;
    push(CR, 15);
    push(CG, 3);
    push(C0, 1);
    push(CR, 1);
    drain("stuck_barrier");
    chk("stuck_steps", ifc.steps, 8'd12);

    // run drops during REMOVE: command finishes, then IDLE at the next SENSE
    ifc.run        = 1'b0;
    ifc.barrier_in = 1'b0;
    push(C0, 3);
    drain("run_drop");

    // Goal cell: done latches and ignores run and sensors
    ifc.run      = 1'b1;
    ifc.under_in = 1'b1;
    push(C0, 1);
    push(CD, 1);
    drain("goal");
    for (int i = 0; i < 6; i++) begin
      ifc.run        = i[0];
      ifc.under_in   = i[1];
      ifc.head_in    = ~i[0];
      ifc.left_in    = i[2];
      ifc.barrier_in = i[1];
      push(CD, 1);
      drain("done_hold");
    end

    // Reset out of DONE clears everything asynchronously
    reset = 1'b1;
    #1;
    chk("reset_done_cmd", {4'h0, obs_cmd()}, 8'h00);
    chk("reset_done_steps", ifc.steps, 8'd0);

    // Reset in the second girar cycle of a right turn
    @(negedge selected_clock);
    reset          = 1'b0;
    ifc.run        = 1'b1;
    ifc.under_in   = 1'b0;
    ifc.barrier_in = 1'b0;
    ifc.left_in    = 1'b1;
    ifc.head_in    = 1'b0;
    push(C0, 1);
    push(CA, 1);
    drain("pre_turn");
    ifc.head_in = 1'b1;
    push(C0, 1);
    push(CG, 2);
    drain("pre_turn_r");
    reset = 1'b1;
    #1;
    chk("mid_turn_girar", {7'h0, ifc.girar}, 8'h00);
    chk("mid_turn_steps", ifc.steps, 8'd0);

    // Step counter saturates at 255
    @(negedge selected_clock);
    reset       = 1'b0;
    ifc.head_in = 1'b0;
    push(C0, 1);
    for (int i = 0; i < 256; i++) begin
      push(CA, 1);
      push(C0, 1);
    end
    drain("saturate");
    chk("sat_steps", ifc.steps, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robo_ctrl.md
ROBO_CTRL -- requirements
Module: robo_ctrl

Interface
REQ-001 The block SHALL have parameter REMOVE_MAX, default 15, meaning the maximum number of consecutive remover cycles before giving up on a barrier.
REQ-002 The block SHALL have parameter RIGHT_TURNS, default 3, meaning the number of girar pulses that make one right turn (girar rotates 90 deg counter-clockwise).
REQ-003 The block SHALL have port selected_clock, input, 1 bit: the system clock, identical to the maze simulator clock_out.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: enables navigation; while 0, no commands are issued.
REQ-006 The block SHALL have port head_in, input, 1 bit: wall (or maze edge) directly ahead.
REQ-007 The block SHALL have port left_in, input, 1 bit: wall (or maze edge) to the left.
REQ-008 The block SHALL have port under_in, input, 1 bit: robot stands on the BLACK goal cell.
REQ-009 The block SHALL have port barrier_in, input, 1 bit: barrier cell (any level) directly ahead.
REQ-010 The block SHALL have ports avancar, girar and remover, outputs, 1 bit each, registered: command signals to the simulator.
REQ-011 The block SHALL have port done, output, 1 bit, registered: goal reached.
REQ-012 The block SHALL have port steps, output, 8 bits, registered: count of issued avancar pulses.

Function
REQ-013 All state SHALL update on posedge selected_clock; sensor inputs SHALL be sampled only in SENSE.
REQ-014 The FSM states SHALL be IDLE, SENSE, TURN_L, FWD, TURN_R, REMOVE and DONE.
REQ-015 At most one of avancar, girar and remover SHALL be high in any cycle.
REQ-016 avancar SHALL be high only in FWD, girar only in TURN_L and TURN_R, and remover only in REMOVE.
REQ-017 Every command state other than TURN_R and REMOVE SHALL last exactly 1 cycle and then return to SENSE, giving the simulator one edge to apply the command before the sensors are re-sampled.
REQ-018 In IDLE, the block SHALL go to SENSE when run=1; otherwise it SHALL stay in IDLE.
REQ-019 In SENSE with run=0, the block SHALL go to IDLE.
REQ-020 In SENSE, the decisions SHALL be evaluated in this priority order:
  a) under_in=1 -> DONE
  b) left_in=0 and left_lock=0 -> TURN_L, and set left_lock
  c) barrier_in=1 -> REMOVE
  d) head_in=0 -> FWD
  e) otherwise -> TURN_R
REQ-021 left_lock SHALL be cleared on entry to FWD, on entry to TURN_R, and by reset; this prevents endless left spinning in open areas.
REQ-022 FWD SHALL increment steps by 1 per pulse, saturating at 255.
REQ-023 TURN_R SHALL assert girar for RIGHT_TURNS consecutive cycles using a 2-bit turn counter and then go to SENSE.
REQ-024 REMOVE SHALL hold remover high while barrier_in=1, counting cycles.
REQ-025 REMOVE SHALL go to SENSE the cycle after barrier_in is sampled 0.
REQ-026 If the REMOVE count reaches REMOVE_MAX, the block SHALL go to TURN_R and treat the barrier as a wall.
REQ-027 A full BARRIER9 clears in 9 cycles, so the default REMOVE_MAX SHALL NOT time out on a BARRIER9.
REQ-028 DONE SHALL hold done=1 with all commands 0 until reset, regardless of run and the sensors.
REQ-029 The block SHALL never issue avancar while head_in=1 or barrier_in=1 was sampled in the deciding SENSE cycle.
REQ-030 If run falls in the middle of a command, that command SHALL complete: TURN_R finishes its count and REMOVE exits on barrier clear or timeout. The block then goes to IDLE at the next SENSE.

Reset
REQ-031 Reset SHALL act asynchronously, at any point including mid-TURN_R or mid-REMOVE.
REQ-032 On reset, the state SHALL go to IDLE and left_lock, the turn counter, the remove counter and steps SHALL all clear to 0.
REQ-033 On reset, avancar, girar, remover and done SHALL all be 0, with no partial command glitch after release.
REQ-034 After reset release, the first command SHALL appear no earlier than 2 edges after run=1 is sampled.

Verification
REQ-035 Straight corridor with left_in=1, head_in=0 and under_in=0: the outputs SHALL alternate SENSE/FWD, giving one avancar pulse every 2 cycles. After 10 pulses, steps=10.
REQ-036 Dead end with left_in=1, head_in=1 and barrier_in=0: girar SHALL be high for exactly 3 consecutive cycles, then SENSE.
REQ-037 Open cell with left_in=0 held: the sequence SHALL be TURN_L (girar 1 cycle), then SENSE, then FWD (avancar 1 cycle). The block SHALL NOT issue a second consecutive TURN_L.
REQ-038 BARRIER9 ahead, with barrier_in dropping after 9 remover cycles: remover SHALL be high for 9 cycles, then SENSE, then FWD.
REQ-039 barrier_in stuck at 1: remover SHALL be high for 15 cycles, then girar for 3 cycles. avancar SHALL never be asserted.
REQ-040 under_in=1 at a SENSE sample: done=1 from the next cycle and SHALL stay 1 with sensors toggling. Reset asserted mid-TURN_R (2nd girar cycle) SHALL drop girar immediately and set steps=0.
